wb_line_fill: RTL and testbench
===============================

WB_LINE_FILL -- requirements
Module: wb_line_fill

Interface
REQ-001 Parameter aw, default 32, address width.
REQ-002 Parameter max_retry, default 3, maximum restarts after wbm_rty_i before reporting an error.
REQ-003 wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  1  line request present.
REQ-006 req_ready_o  output  1  block idle; a request is accepted when req_valid_i & req_ready_o.
REQ-007 req_adr_i  input  aw  byte address; bits [3:2] give the critical word and bits [1:0] are ignored.
REQ-008 req_we_i  input  1  1 = write-back line, 0 = refill line.
REQ-009 req_line_i  input  128  write-back data; word i at bits [127-32i -: 32].
REQ-010 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 rsp_err_o  output  1  qualifies rsp_valid_o; 1 = bus error or retries exhausted.
REQ-012 rsp_line_o  output  128  refill data, same word packing as req_line_i; stable until the next accept.
REQ-013 wbm_adr_o  output  aw; wbm_dat_o  output  32; wbm_sel_o  output  4; wbm_cti_o  output  3; wbm_bte_o  output  2; wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each; Wishbone B3 master.
REQ-014 wbm_dat_i  input  32; wbm_ack_i, wbm_err_i, wbm_rty_i  input  1 each.

Function
REQ-015 States: IDLE, BURST, RETRY, RESP; req_ready_o = 1 only in IDLE.
REQ-016 Accept: latch the address, we and line; the next cycle enter BURST with wbm_adr_o = {req_adr_i[aw-1:2],2'b00}.
REQ-017 BURST: cyc=stb=1, sel=4'hf, bte=2'b01 (4-beat wrap), we=latched we; stb held high with no master wait states.
REQ-018 Beat counter 0..3; cti=3'b010 for beats 0-2 and 3'b111 for beat 3.
REQ-019 On each ack: adr[3:2] increments modulo 4 in the following cycle and adr[aw-1:4] never changes (e.g. start 0x0C gives 0x0C, 0x00, 0x04, 0x08).
REQ-020 Write: wbm_dat_o = latched word adr[3:2] combinationally, so data tracks the address.
REQ-021 Read: on ack, capture wbm_dat_i into word adr[3:2] of the line register.
REQ-022 Ack on beat 3: next cycle cyc=stb=0, state RESP, retry count cleared.
REQ-023 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; back-to-back requests therefore have at least 2 idle-bus cycles between them.
REQ-024 wbm_err_i in BURST (any beat): next cycle cyc=stb=0 and RESP with rsp_err_o=1.
REQ-025 Partially captured words of an errored refill are undefined.
REQ-026 wbm_rty_i in BURST with retry count < max_retry: increment the count, drop cyc for exactly one cycle (RETRY), then restart the burst from the original critical-word address with beat counter 0.
REQ-027 wbm_rty_i with retry count = max_retry: behave as err.
REQ-028 Priority when several of err/rty/ack are asserted in one cycle: err > rty > ack.
REQ-029 Strobes received outside BURST are ignored.
REQ-030 rsp_err_o = 0 whenever rsp_valid_o = 0.

Reset
REQ-031 On wb_rst_i, next edge: state IDLE; cyc, stb, we, rsp_valid_o, rsp_err_o = 0; cti, bte, adr, beat and retry counters = 0; rsp_line_o = 0.
REQ-032 Reset mid-burst abandons the transaction: no response pulse, and the bus is released on the reset edge.
REQ-033 Reset has priority over every other event, including a simultaneous ack, err or request.

Structure
REQ-034 Shared package wb_b3_pkg holds the CTI constants (CLASSIC 000, CONST 001, INC 010, EOB 111) and the BTE constants (LINEAR 00, WRAP4 01, WRAP8 10, WRAP16 11).
REQ-035 The state encoding is local to this module.
REQ-036 The block has no sub-modules; the bus slave is the 20 KB burst RAM slave of the same subsystem.

Verification
REQ-037 Refill at 0x104 against the RAM slave with words 0x100-0x10C = A0,A1,A2,A3 -> addresses 0x104, 0x108, 0x10C, 0x100; cti 010,010,010,111; rsp_line_o = {A0,A1,A2,A3}; rsp_err_o = 0; 4 consecutive acks.
REQ-038 Write-back at 0x200 of {11111111,22222222,33333333,44444444} then refill at 0x20C -> readback line identical and write beats carry sel 4'hf.
REQ-039 Refill at address 0x00FF_0000 (slave out of range) -> err on beat 0; cyc low the next cycle; rsp_valid_o = 1 with rsp_err_o = 1.
REQ-040 Slave model asserts rty on beat 2 twice, then completes -> three bursts, each restarting at the critical word with one idle cycle between them, and a correct line with no error.
REQ-041 rty four times with max_retry = 3 -> error response after the fourth rty.
REQ-042 wb_rst_i asserted on beat 1 of a refill -> cyc = 0 and req_ready_o = 1 after the reset edge, with no rsp_valid_o pulse.

Source files
------------

// File: rtl/wb_b3_pkg.sv
// Wishbone B3 cycle-type and burst-type encodings shared across the subsystem,
// plus a helper locating a 32-bit word inside a 128-bit line (word 0 in the MSBs).
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Bit offset of the LSB of word idx: word i occupies [127-32i -: 32].
  function automatic logic [6:0] line_word_base(input logic [1:0] idx);
    return {~idx, 5'b00000};
  endfunction

endpackage

// File: rtl/wb_line_fill.sv
// Cache-line engine: moves one 128-bit line over a Wishbone B3 4-beat wrapping
// burst, critical word first, with bounded restart on retry.
//
// Handshakes: a request transfers on the rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only while idle. Completion is
// a single-cycle rsp_valid_o pulse, with rsp_err_o meaningful only alongside it.
module wb_line_fill
  import wb_b3_pkg::*;
#(
  parameter int aw        = 32,
  parameter int max_retry = 3
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [aw-1:0] req_adr_i,
  input  logic          req_we_i,
  input  logic [127:0]  req_line_i,
  output logic          rsp_valid_o,
  output logic          rsp_err_o,
  output logic [127:0]  rsp_line_o,
  output logic [aw-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  output logic [2:0]    wbm_cti_o,
  output logic [1:0]    wbm_bte_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic          wbm_rty_i,
  output logic [1:0]    dbg_state_o
);

  localparam int RW = (max_retry < 2) ? 1 : $clog2(max_retry + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_RETRY = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [aw-1:0]   r_adr;
  logic [1:0]      r_crit;
  logic            r_we;
  logic [127:0]    r_line;
  logic [1:0]      r_beat;
  logic [RW-1:0]   r_retry;

  logic            w_fail;
  logic            w_restart;
  logic [6:0]      w_base;
  logic            w_unused;

  // Retry budget exhausted turns a retry into an error; err outranks both.
  assign w_fail    = wbm_err_i | (wbm_rty_i & (r_retry == RW'(max_retry)));
  assign w_restart = wbm_rty_i & ~w_fail;
  assign w_base    = line_word_base(r_adr[3:2]);
  assign w_unused  = &{1'b0, req_adr_i[1:0]};

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_line_o  = r_line;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_line[w_base +: 32];
  assign dbg_state_o = r_state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_adr       <= '0;
      r_crit      <= '0;
      r_we        <= 1'b0;
      r_line      <= '0;
      r_beat      <= '0;
      r_retry     <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_cti_o   <= CTI_CLASSIC;
      wbm_bte_o   <= BTE_LINEAR;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_adr     <= {req_adr_i[aw-1:2], 2'b00};
            r_crit    <= req_adr_i[3:2];
            r_we      <= req_we_i;
            r_line    <= req_line_i;
            r_beat    <= '0;
            r_retry   <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= req_we_i;
            wbm_sel_o <= 4'hf;
            wbm_cti_o <= CTI_INC;
            wbm_bte_o <= BTE_WRAP4;
            r_state   <= S_BURST;
          end
        end

        S_BURST: begin
          if (w_fail) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_cti_o   <= CTI_CLASSIC;
            wbm_bte_o   <= BTE_LINEAR;
            r_retry     <= '0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_restart) begin
            r_retry   <= r_retry + 1'b1;
            r_adr     <= {r_adr[aw-1:4], r_crit, 2'b00};
            r_beat    <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_cti_o <= CTI_INC;
            r_state   <= S_RETRY;
          end else if (wbm_ack_i) begin
            if (!r_we) begin
              r_line[w_base +: 32] <= wbm_dat_i;
            end
            r_adr[3:2] <= r_adr[3:2] + 2'd1;
            if (r_beat == 2'd3) begin
              wbm_cyc_o   <= 1'b0;
              wbm_stb_o   <= 1'b0;
              wbm_we_o    <= 1'b0;
              wbm_sel_o   <= 4'h0;
              wbm_cti_o   <= CTI_CLASSIC;
              wbm_bte_o   <= BTE_LINEAR;
              r_retry     <= '0;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              r_state     <= S_RESP;
            end else begin
              r_beat    <= r_beat + 2'd1;
              wbm_cti_o <= (r_beat == 2'd2) ? CTI_EOB : CTI_INC;
            end
          end
        end

        S_RETRY: begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          r_state   <= S_BURST;
        end

        S_RESP: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_line_fill.sv
// Directed bench for wb_line_fill against a 20 KB zero-wait burst RAM slave
// model with injectable retry and out-of-range error responses.
module tb_wb_line_fill;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [31:0]   req_adr_i = '0;
  logic          req_we_i = 1'b0;
  logic [127:0]  req_line_i = '0;
  logic          rsp_valid_o, rsp_err_o;
  logic [127:0]  rsp_line_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]    wbm_sel_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic          wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [1:0]    dbg_state_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_line_fill #(.aw(32), .max_retry(3)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_adr_i(req_adr_i), .req_we_i(req_we_i), .req_line_i(req_line_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_line_o(rsp_line_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- slave model ----------------
  localparam logic [31:0] A0 = 32'hA0A0_0000, A1 = 32'hA1A1_1111;
  localparam logic [31:0] A2 = 32'hA2A2_2222, A3 = 32'hA3A3_3333;

  logic [31:0] mem [0:5119];
  logic        s_strobe, s_in_range;
  logic [12:0] s_idx;
  int          tb_beat = 0;
  int          rty_seen = 0;
  int          rty_limit = 0;
  int          rty_beat = 2;

  assign s_strobe   = wbm_cyc_o & wbm_stb_o;
  assign s_in_range = (wbm_adr_o < 32'd20480);
  assign s_idx      = wbm_adr_o[14:2];
  assign wbm_err_i  = s_strobe & ~s_in_range;
  assign wbm_rty_i  = s_strobe & s_in_range & (rty_seen < rty_limit) & (tb_beat == rty_beat);
  assign wbm_ack_i  = s_strobe & s_in_range & ~wbm_rty_i;
  assign wbm_dat_i  = s_in_range ? mem[s_idx] : 32'h0;

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tb_beat  <= 0;
      mem[64]  <= A0;
      mem[65]  <= A1;
      mem[66]  <= A2;
      mem[67]  <= A3;
    end else if (!wbm_cyc_o) begin
      tb_beat <= 0;
    end else if (wbm_rty_i) begin
      tb_beat  <= 0;
      rty_seen <= rty_seen + 1;
    end else if (wbm_ack_i) begin
      tb_beat <= tb_beat + 1;
      if (wbm_we_o) mem[s_idx] <= wbm_dat_o;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_adr[$], log_dat[$];
  logic [2:0]  log_cti[$];
  logic [3:0]  log_sel[$];
  logic        log_we[$];
  logic [1:0]  log_bte[$];
  int          log_cyc[$];
  logic        got_rsp, rsp_err_s, rsp_bus_cyc;
  logic [127:0] rsp_line_s;
  int          rsp_cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drains exp_q against a logged stream.
  task automatic chk_stream(input string tag, input logic [31:0] got[$]);
    chk({tag, "_count"}, 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < got.size() && exp_q.size() > 0; i++) begin
      chk($sformatf("%s_%0d", tag, i), 128'(got[i]), 128'(exp_q.pop_front()));
    end
    exp_q.delete();
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [127:0] line);
    log_adr.delete(); log_dat.delete(); log_cti.delete(); log_sel.delete();
    log_we.delete(); log_bte.delete(); log_cyc.delete();
    got_rsp = 1'b0; rsp_err_s = 1'b0; rsp_line_s = '0; rsp_cyc = -1; rsp_bus_cyc = 1'b1;
    @(negedge wb_clk_i);
    chk("ready_before_req", 128'(req_ready_o), 128'(1));
    req_adr_i = adr; req_we_i = we; req_line_i = line; req_valid_i = 1'b1;
    @(posedge wb_clk_i);
    #1 req_valid_i = 1'b0;
    for (int n = 0; n < 100 && !got_rsp; n++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && wbm_stb_o) begin
        log_adr.push_back(wbm_adr_o); log_dat.push_back(wbm_dat_o);
        log_cti.push_back(wbm_cti_o); log_sel.push_back(wbm_sel_o);
        log_we.push_back(wbm_we_o);   log_bte.push_back(wbm_bte_o);
        log_cyc.push_back(n);
      end
      if (rsp_valid_o) begin
        got_rsp = 1'b1; rsp_err_s = rsp_err_o; rsp_line_s = rsp_line_o;
        rsp_cyc = n; rsp_bus_cyc = wbm_cyc_o;
      end
    end
    chk("rsp_seen", 128'(got_rsp), 128'(1));
    @(negedge wb_clk_i);
    chk("rsp_one_cycle", 128'(rsp_valid_o), 128'(0));
    chk("rsp_err_without_valid", 128'(rsp_err_o), 128'(0));
  endtask

  task automatic chk_cycles(input string tag, input int exp_c[$]);
    logic [31:0] got[$];
    foreach (log_cyc[i]) got.push_back(32'(log_cyc[i]));
    foreach (exp_c[i]) exp_q.push_back(32'(exp_c[i]));
    chk_stream(tag, got);
  endtask

  initial begin
    int pulses;
    logic [31:0] cti_w[$], sel_w[$];

    // reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_cyc", 128'(wbm_cyc_o), 128'(0));
    chk("rst_stb", 128'(wbm_stb_o), 128'(0));
    chk("rst_we", 128'(wbm_we_o), 128'(0));
    chk("rst_ready", 128'(req_ready_o), 128'(1));
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    chk("rst_rsp_err", 128'(rsp_err_o), 128'(0));
    chk("rst_adr", 128'(wbm_adr_o), 128'(0));
    chk("rst_cti_bte", 128'({wbm_cti_o, wbm_bte_o}), 128'(0));
    chk("rst_line", rsp_line_o, 128'(0));
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // refill at 0x104, critical word 1
    run_txn(32'h104, 1'b0, '0);
    exp_q = '{32'h104, 32'h108, 32'h10C, 32'h100};
    chk_stream("refill_adr", log_adr);
    foreach (log_cti[i]) cti_w.push_back(32'(log_cti[i]));
    exp_q = '{32'h2, 32'h2, 32'h2, 32'h7};
    chk_stream("refill_cti", cti_w);
    chk_cycles("refill_ack_cycles", '{0, 1, 2, 3});
    chk("refill_bte", 128'(log_bte[0]), 128'(2'b01));
    chk("refill_we", 128'(log_we[0]), 128'(0));
    chk("refill_line", rsp_line_s, {A0, A1, A2, A3});
    chk("refill_err", 128'(rsp_err_s), 128'(0));
    chk("refill_rsp_cycle", 128'(rsp_cyc), 128'(4));
    chk("refill_bus_idle_at_rsp", 128'(rsp_bus_cyc), 128'(0));

    // write-back at 0x200 then read it back from 0x20C
    run_txn(32'h200, 1'b1, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    exp_q = '{32'h200, 32'h204, 32'h208, 32'h20C};
    chk_stream("wb_adr", log_adr);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    chk_stream("wb_dat", log_dat);
    foreach (log_sel[i]) sel_w.push_back(32'(log_sel[i]));
    exp_q = '{32'hf, 32'hf, 32'hf, 32'hf};
    chk_stream("wb_sel", sel_w);
    chk("wb_we", 128'(log_we[0]), 128'(1));
    chk("wb_err", 128'(rsp_err_s), 128'(0));
    run_txn(32'h20C, 1'b0, '0);
    exp_q = '{32'h20C, 32'h200, 32'h204, 32'h208};
    chk_stream("rb_adr", log_adr);
    chk("rb_line", rsp_line_s, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});

    // out-of-range refill: error on beat 0
    run_txn(32'h00FF_0000, 1'b0, '0);
    chk("oor_beats", 128'(log_adr.size()), 128'(1));
    chk("oor_rsp_cycle", 128'(rsp_cyc), 128'(1));
    chk("oor_cyc_dropped", 128'(rsp_bus_cyc), 128'(0));
    chk("oor_err", 128'(rsp_err_s), 128'(1));

    // two retries on beat 2, then success
    rty_beat = 2;
    rty_limit = rty_seen + 2;
    run_txn(32'h104, 1'b0, '0);
    exp_q = '{32'h104, 32'h108, 32'h10C, 32'h104, 32'h108, 32'h10C,
              32'h104, 32'h108, 32'h10C, 32'h100};
    chk_stream("rty2_adr", log_adr);
    chk_cycles("rty2_cycles", '{0, 1, 2, 4, 5, 6, 8, 9, 10, 11});
    chk("rty2_restart_cti", 128'(log_cti[3]), 128'(3'b010));
    chk("rty2_line", rsp_line_s, {A0, A1, A2, A3});
    chk("rty2_err", 128'(rsp_err_s), 128'(0));

    // four retries on beat 0 exceed max_retry = 3
    rty_beat = 0;
    rty_limit = rty_seen + 4;
    run_txn(32'h104, 1'b0, '0);
    exp_q = '{32'h104, 32'h104, 32'h104, 32'h104};
    chk_stream("rty4_adr", log_adr);
    chk_cycles("rty4_cycles", '{0, 2, 4, 6});
    chk("rty4_rsp_cycle", 128'(rsp_cyc), 128'(7));
    chk("rty4_err", 128'(rsp_err_s), 128'(1));

    // reset on beat 1 of a refill
    rty_limit = rty_seen;
    @(negedge wb_clk_i);
    req_adr_i = 32'h100; req_we_i = 1'b0; req_line_i = '0; req_valid_i = 1'b1;
    @(posedge wb_clk_i);
    #1 req_valid_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge wb_clk_i);
      if (s_strobe && tb_beat == 1) break;
    end
    chk("mid_reached_beat1", 128'(s_strobe && tb_beat == 1), 128'(1));
    chk("mid_line_nonzero", 128'(rsp_line_o != '0), 128'(1));
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    chk("mid_rst_cyc", 128'(wbm_cyc_o), 128'(0));
    chk("mid_rst_stb", 128'(wbm_stb_o), 128'(0));
    chk("mid_rst_ready", 128'(req_ready_o), 128'(1));
    chk("mid_rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    chk("mid_rst_line", rsp_line_o, 128'(0));
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge wb_clk_i);
      if (rsp_valid_o || wbm_cyc_o) pulses++;
    end
    chk("mid_rst_no_activity", 128'(pulses), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
